// File: rtl/lifo_arbiter_if.sv
// lifo_arbiter_if
//   Requester-side bus of the two-port LIFO arbiter.
//   master : requester logic (drives req/op/wdata, receives gnt/err/rvalid/rdata)
//   slave  : lifo_arbiter
// Signals
//   req[1:0]    request strobes, held until the matching gnt
//   op[1:0]     1 = push, 0 = pop, per requester
//   wdata0/1    push data per requester
//   gnt[1:0]    acceptance pulse
//   err[1:0]    refusal pulse (coincides with gnt)
//   rvalid[1:0] pop result valid pulse
//   rdata       shared pop result
interface lifo_arbiter_if #(
  parameter int DW = 4
);
  logic [1:0]    req;
  logic [1:0]    op;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    err;
  logic [1:0]    rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, op, wdata0, wdata1,
    input  gnt, err, rvalid, rdata
  );

  modport slave (
    input  req, op, wdata0, wdata1,
    output gnt, err, rvalid, rdata
  );
endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter
//   Shares one external LIFO stack between two requesters. Each request is a
//   single push or pop; simultaneous requests alternate round-robin. The block
//   tracks stack occupancy itself and refuses overflowing pushes and
//   underflowing pops without touching the stack.
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        requester bus (lifo_arbiter_if.slave)
//   stk_push   push strobe to the stack
//   stk_pop    pop strobe to the stack
//   stk_wdata  push data to the stack
//   stk_rdata  stack pop data, valid the cycle after stk_pop
//   occ        current number of stack entries, 0..DEPTH
//   err_cnt    saturating refusal counter (only with LIFO_ARBITER_ERRCNT_EN)
// Build option
//   LIFO_ARBITER_ERRCNT_EN : when defined, adds the 8-bit err_cnt output.
module lifo_arbiter #(
  parameter  int DW    = 4,
  parameter  int DEPTH = 8,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  lifo_arbiter_if.slave bus,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic [OW-1:0] occ
`ifdef LIFO_ARBITER_ERRCNT_EN
  ,
  output logic [7:0]    err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    CAPT   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          w_reg;       // current winner
  logic          op_reg;      // winner's operation (1 = push)
  logic [DW-1:0] data_reg;    // winner's push data
  logic          last_reg;    // previous winner, for round-robin
  logic [OW-1:0] occ_reg;
  logic [DW-1:0] rdata_reg;

  logic win;
  logic full, empty;
  logic issue, do_push, do_pop, refuse, capt;

  // Winner selection: a lone requester wins outright, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    win = 1'b0;
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_reg;
      default: win = 1'b0;
    endcase
  end

  assign full  = (occ_reg == OW'(DEPTH));
  assign empty = (occ_reg == '0);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    refuse     = 1'b0;
    capt       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|bus.req) state_next = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (op_reg && !full) begin
          do_push    = 1'b1;
          state_next = IDLE;
        end else if (!op_reg && !empty) begin
          do_pop     = 1'b1;
          state_next = RDWAIT;
        end else begin
          refuse     = 1'b1;
          state_next = IDLE;
        end
      end
      RDWAIT: state_next = CAPT;
      CAPT: begin
        capt       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      w_reg     <= 1'b0;
      op_reg    <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b1;
      occ_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && |bus.req) begin
        w_reg    <= win;
        last_reg <= win;
        op_reg   <= bus.op[win];
        data_reg <= win ? bus.wdata1 : bus.wdata0;
      end
      // full/empty gating in the FSM keeps occ inside 0..DEPTH
      if (do_push) occ_reg <= occ_reg + OW'(1);
      if (do_pop)  occ_reg <= occ_reg - OW'(1);
      if (state_reg == RDWAIT) rdata_reg <= stk_rdata;
    end
  end

  // Strobes are qualified with rst_n so that a reset landing mid-operation
  // silences gnt/err/rvalid and the stack strobes in the very same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign bus.gnt[gi]    = rst_n & issue  & (w_reg == 1'(gi));
      assign bus.err[gi]    = rst_n & refuse & (w_reg == 1'(gi));
      assign bus.rvalid[gi] = rst_n & capt   & (w_reg == 1'(gi));
    end
  endgenerate

  assign stk_push  = rst_n & do_push;
  assign stk_pop   = rst_n & do_pop;
  assign stk_wdata = stk_push ? data_reg : '0;
  assign occ       = occ_reg;
  assign bus.rdata = rdata_reg;

`ifdef LIFO_ARBITER_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (refuse && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter
//   Directed bench for lifo_arbiter with a behavioural 8 x 4 stack attached
//   to the stk_* port. Expected values are hand-computed per step.
module tb_lifo_arbiter;

  logic       clk;
  logic       rst_n;
  logic       stk_push, stk_pop;
  logic [3:0] stk_wdata, stk_rdata;
  logic [3:0] occ;
`ifdef LIFO_ARBITER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  lifo_arbiter_if #(.DW(4)) bus ();

  lifo_arbiter #(.DW(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata),
    .occ       (occ)
`ifdef LIFO_ARBITER_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack, reset together with the arbiter.
  logic [3:0] mem [8];
  logic [3:0] sp;
  always @(posedge clk) begin
    if (!rst_n) begin
      sp        <= '0;
      stk_rdata <= '0;
    end else if (stk_push) begin
      if (sp < 4'd8) mem[sp[2:0]] <= stk_wdata;
      sp <= sp + 4'd1;
    end else if (stk_pop) begin
      if (sp != 4'd0) stk_rdata <= mem[3'(sp - 4'd1)];
      sp <= sp - 4'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request by requester i, issued from IDLE. Checks grant timing,
  // strobes, occupancy and (for pops) the result two cycles after gnt.
  task automatic single_op(input string tag, input int i, input bit push,
                           input logic [3:0] d, input bit exp_err,
                           input logic [3:0] exp_rd, input logic [3:0] exp_occ);
    logic [1:0] m;
    m = 2'(1 << i);
    bus.req[i] = 1'b1;
    bus.op[i]  = push;
    if (i == 0) bus.wdata0 = d; else bus.wdata1 = d;
    tick();
    chk({tag, " gnt"}, 32'(bus.gnt), 32'(m));
    chk({tag, " err"}, 32'(bus.err), exp_err ? 32'(m) : 32'd0);
    chk({tag, " stk_push"}, 32'(stk_push), 32'(push && !exp_err));
    chk({tag, " stk_pop"}, 32'(stk_pop), 32'(!push && !exp_err));
    if (push && !exp_err) chk({tag, " stk_wdata"}, 32'(stk_wdata), 32'(d));
    bus.req[i] = 1'b0;
    tick();
    chk({tag, " occ"}, 32'(occ), 32'(exp_occ));
    chk({tag, " rvalid early"}, 32'(bus.rvalid), 32'd0);
    if (!push && !exp_err) begin
      tick();
      chk({tag, " rvalid"}, 32'(bus.rvalid), 32'(m));
      chk({tag, " rdata"}, 32'(bus.rdata), 32'(exp_rd));
      tick();
      chk({tag, " rvalid end"}, 32'(bus.rvalid), 32'd0);
    end
    $display("%s: req%0d %s data=%h err=%0b occ=%0d rdata=%h", tag, i,
             push ? "push" : "pop", d, bus.err[i], occ, bus.rdata);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.req    = 2'($urandom_range(0, 3));
      bus.op     = 2'($urandom_range(0, 3));
      bus.wdata0 = 4'($urandom_range(0, 15));
      bus.wdata1 = 4'($urandom_range(0, 15));
      tick();
      chk({tag, " gnt"}, 32'(bus.gnt), 32'd0);
      chk({tag, " err"}, 32'(bus.err), 32'd0);
      chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd0);
      chk({tag, " stk"}, 32'({stk_push, stk_pop}), 32'd0);
      chk({tag, " occ"}, 32'(occ), 32'd0);
      chk({tag, " rdata"}, 32'(bus.rdata), 32'd0);
    end
    bus.req = 2'b00;
    bus.op  = 2'b00;
    rst_n   = 1'b1;
    tick();
    $display("%s: reset released occ=%0d", tag, occ);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.req    = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;

    // 1. reset with random requests
    do_reset("t1 reset");

    // 2. push A by req0, pop by req1
    single_op("t2 push", 0, 1'b1, 4'hA, 1'b0, 4'h0, 4'd1);
    single_op("t2 pop", 1, 1'b0, 4'h0, 1'b0, 4'hA, 4'd0);

    // 3. simultaneous pushes: req0 first after reset, then req1
    do_reset("t3 reset");
    bus.op     = 2'b11;
    bus.wdata0 = 4'h1;
    bus.wdata1 = 4'h2;
    bus.req    = 2'b11;
    tick();
    chk("t3 first gnt", 32'(bus.gnt), 32'h1);
    chk("t3 first wdata", 32'(stk_wdata), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    chk("t3 idle gnt", 32'(bus.gnt), 32'h0);
    tick();
    chk("t3 second gnt", 32'(bus.gnt), 32'h2);
    chk("t3 second wdata", 32'(stk_wdata), 32'h2);
    bus.req[1] = 1'b0;
    tick();
    chk("t3 occ", 32'(occ), 32'd2);
    $display("t3 pushes: both granted occ=%0d", occ);
    single_op("t3 pop a", 0, 1'b0, 4'h0, 1'b0, 4'h2, 4'd1);
    single_op("t3 pop b", 0, 1'b0, 4'h0, 1'b0, 4'h1, 4'd0);

    // 4. fill with 8 pushes by req1, then overflow
    for (int k = 0; k < 8; k++)
      single_op($sformatf("t4 push%0d", k), 1, 1'b1, 4'(k + 3), 1'b0, 4'h0, 4'(k + 1));
    single_op("t4 overflow", 1, 1'b1, 4'hF, 1'b1, 4'h0, 4'd8);
`ifdef LIFO_ARBITER_ERRCNT_EN
    chk("t4 err_cnt", 32'(err_cnt), 32'd1);
`endif
    single_op("t4 top pop", 0, 1'b0, 4'h0, 1'b0, 4'hA, 4'd7);

    // 5. underflow
    do_reset("t5 reset");
    single_op("t5 underflow", 0, 1'b0, 4'h0, 1'b1, 4'h0, 4'd0);
    tick();
    chk("t5 no rvalid", 32'(bus.rvalid), 32'd0);
    chk("t5 rdata held", 32'(bus.rdata), 32'd0);

    // 6. reset while waiting for pop data
    single_op("t6 push", 0, 1'b1, 4'h5, 1'b0, 4'h0, 4'd1);
    bus.req[0] = 1'b1;
    bus.op[0]  = 1'b0;
    tick();
    chk("t6 pop gnt", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    chk("t6 rvalid in reset", 32'(bus.rvalid), 32'd0);
    tick();
    chk("t6 rvalid after reset", 32'(bus.rvalid), 32'd0);
    chk("t6 occ", 32'(occ), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("t6 rvalid after release", 32'(bus.rvalid), 32'd0);
    bus.req[0] = 1'b1;
    bus.op[0]  = 1'b1;
    bus.wdata0 = 4'h9;
    tick();
    chk("t6 gnt 2 after release", 32'(bus.gnt), 32'h1);
    chk("t6 stk_push", 32'(stk_push), 32'd1);
    bus.req[0] = 1'b0;
    tick();
    chk("t6 occ after push", 32'(occ), 32'd1);
    $display("t6 reset in RDWAIT: occ=%0d", occ);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
